// File: rtl/instruction_aligner_pkg.sv
// -----------------------------------------------------------------------------
// instruction_aligner_pkg
//   Shared constants for the instruction aligner and its neighbours in the
//   fetch stage: parcel width, parcel buffer depth and the low-bit pattern
//   that marks a full-length (32-bit) instruction.
// -----------------------------------------------------------------------------
package instruction_aligner_pkg;

    localparam int unsigned PARCEL_W  = 16;
    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned BUF_W     = PARCEL_W * BUF_DEPTH;
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);

    // Parcels whose bits 1:0 equal this value start a 32-bit instruction.
    localparam logic [1:0] OPC_FULL_LEN = 2'b11;

    function automatic logic is_full_len(input logic [PARCEL_W-1:0] parcel);
        return parcel[1:0] == OPC_FULL_LEN;
    endfunction

endpackage

// File: rtl/instruction_aligner.sv
// -----------------------------------------------------------------------------
// instruction_aligner
//   Turns a stream of sequential 32-bit fetch words into a stream of whole
//   instructions (16-bit compressed or 32-bit), tracking each instruction's PC.
//   Up to four halfword parcels are buffered, oldest in bits 15:0.
//
// Ports
//   clk             in   clock, rising edge
//   reset           in   asynchronous active-high reset
//   flush           in   drop buffered parcels, restart at flush_pc
//   flush_pc        in   restart address (bit 0 ignored)
//   fetch_valid     in   fetch_data holds the next sequential memory word
//   fetch_data      in   little-endian word, halfword 0 = bits 15:0
//   fetch_ready     out  word accepted this cycle when fetch_valid is high
//   out_valid       out  out_instruction holds one complete instruction
//   out_ready       in   consumer takes the instruction this cycle
//   out_instruction out  instruction; compressed ones are zero-extended
//   out_compressed  out  instruction bits 1:0 != 2'b11
//   out_pc          out  address of out_instruction
// -----------------------------------------------------------------------------
module instruction_aligner
    import instruction_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    output logic        fetch_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic        out_compressed,
    output logic [31:0] out_pc
);

    // SKIP_HALF: the next accepted word starts mid-word, so its halfword 0
    // precedes the current PC and must be dropped.
    typedef enum logic {
        ST_RUN,
        ST_SKIP_HALF
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q,   buf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        pc_q,    pc_d;

    logic [PARCEL_W-1:0] parcel0;
    logic [PARCEL_W-1:0] parcel1;
    logic                full_len;
    logic                accept;
    logic                emit;
    logic [CNT_W-1:0]    consumed;
    logic [CNT_W-1:0]    kept;
    logic [BUF_W-1:0]    shifted;
    logic [BUF_W-1:0]    app_data;
    logic [BUF_W-1:0]    app_mask;

    // ------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------
    assign parcel0  = buf_q[PARCEL_W-1:0];
    assign parcel1  = buf_q[2*PARCEL_W-1:PARCEL_W];
    assign full_len = is_full_len(parcel0);

    // A 32-bit instruction needs both parcels present; parcels above count
    // are never looked at for validity.
    assign out_valid = ((count_q >= CNT_ONE) && !full_len) || (count_q >= CNT_TWO);

    assign out_instruction = full_len ? {parcel1, parcel0}
                                      : {{PARCEL_W{1'b0}}, parcel0};
    assign out_compressed  = !full_len;
    assign out_pc          = pc_q;

    // Room for a full word means at most two parcels held.
    assign fetch_ready = !reset && !flush && (count_q <= CNT_TWO);

    assign accept = fetch_valid && fetch_ready;
    assign emit   = out_valid && out_ready && !flush;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        count_d  = count_q;
        pc_d     = pc_q;
        consumed = '0;
        app_data = '0;
        app_mask = '0;

        if (emit) begin
            consumed = full_len ? CNT_TWO : CNT_ONE;
            pc_d     = pc_q + (full_len ? 32'd4 : 32'd2);
        end

        // Consume first, then append behind whatever parcels remain.
        kept    = count_q - consumed;
        shifted = buf_q >> (PARCEL_W * consumed);
        buf_d   = shifted;
        count_d = kept;

        if (accept) begin
            if (state_q == ST_SKIP_HALF) begin
                app_data = BUF_W'(fetch_data[31:16]);
                app_mask = BUF_W'({PARCEL_W{1'b1}});
                count_d  = kept + CNT_ONE;
                state_d  = ST_RUN;
            end else begin
                app_data = BUF_W'(fetch_data);
                app_mask = BUF_W'({2*PARCEL_W{1'b1}});
                count_d  = kept + CNT_TWO;
            end
            app_data = app_data << (PARCEL_W * kept);
            app_mask = app_mask << (PARCEL_W * kept);
            buf_d    = (shifted & ~app_mask) | app_data;
        end

        // Flush overrides everything; leftover buffer bits are dead once
        // count is zero.
        if (flush) begin
            buf_d   = buf_q;
            count_d = '0;
            pc_d    = {flush_pc[31:1], 1'b0};
            state_d = flush_pc[1] ? ST_SKIP_HALF : ST_RUN;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_PC[1] ? ST_SKIP_HALF : ST_RUN;
            buf_q   <= '0;
            count_q <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: doc/instruction_aligner.md
INSTRUCTION_ALIGNER -- requirements
Module: instruction_aligner

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, halfword-aligned address of the first instruction after reset.
REQ-002 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: flush  in  1  discard all buffered parcels; restart alignment at flush_pc.
REQ-005 Port: flush_pc  in  32  restart address; bit 0 ignored.
REQ-006 Port: fetch_valid  in  1  fetch_data holds the next sequential 32-bit memory word.
REQ-007 Port: fetch_data  in  32  little-endian word; halfword 0 = bits 15:0.
REQ-008 Port: fetch_ready  out  1  aligner accepts fetch_data this cycle.
REQ-009 Port: out_valid  out  1  out_instruction holds one complete instruction.
REQ-010 Port: out_ready  in  1  consumer takes the instruction this cycle.
REQ-011 Port: out_instruction  out  32  raw instruction; for a compressed instruction, bits 15:0 = parcel, bits 31:16 = 0.
REQ-012 Port: out_compressed  out  1  out_instruction bits 1:0 != 2'b11.
REQ-013 Port: out_pc  out  32  address of out_instruction.

Function
REQ-014 The aligner SHALL hold up to 4 halfword parcels in a 64-bit FIFO-ordered buffer with a count of 0..4; the oldest parcel is always in bits 15:0.
REQ-015 Accept: fetch_ready = (count <= 2) && !flush; handshake = fetch_valid && fetch_ready; an accepted word appends 2 parcels (halfword 0 first).
REQ-016 Emit: out_valid = (count >= 1 && parcel0[1:0] != 2'b11) || (count >= 2); a 16-bit instruction consumes 1 parcel, a 32-bit instruction consumes 2.
REQ-017 A 32-bit instruction whose upper half is not yet buffered (count = 1, parcel0[1:0] = 2'b11) SHALL hold out_valid low until the next word is accepted.
REQ-018 Outputs SHALL be decoded combinationally from registered state; a word accepted in cycle N is presentable in cycle N+1 (latency 1).
REQ-019 While out_valid && !out_ready, out_instruction, out_compressed and out_pc SHALL stay stable, including across a simultaneous accept.
REQ-020 Accept and emit in the same cycle SHALL both take effect: count_next = count + 2*accept - consumed; the buffer shifts down by the consumed parcels before appending.
REQ-021 out_pc SHALL advance by 2 or 4 on each emit handshake and wrap modulo 2^32.
REQ-022 State machine: RUN (normal), SKIP_HALF (next accepted word's halfword 0 is discarded, halfword 1 only appended, count += 1); returns to RUN after that accept.
REQ-023 flush SHALL have priority over accept and emit: next cycle count = 0, out_pc = {flush_pc[31:1], 1'b0}, state = SKIP_HALF if flush_pc[1] else RUN; no handshake completes in a flush cycle.
REQ-024 Buffer contents above count are don't-care and SHALL never affect outputs.

Reset
REQ-025 While reset is high: count = 0, state = SKIP_HALF if RESET_PC[1] else RUN, out_pc = RESET_PC, buffer = 0; out_valid = 0; fetch_ready = 0 while reset asserted, 1 from the first cycle after release.
REQ-026 Reset asserted mid-instruction SHALL discard any partial 32-bit instruction.

Structure
REQ-027 Parcel width (16), buffer depth (4) and the compressed-detect opcode constant (2'b11) SHALL live in the shared common package; the state enum stays local.
REQ-028 Single flat module, no sub-modules; the compressed-instruction expander is instantiated next to it by the fetch stage, not inside it.

Verification
REQ-029 Reset, RESET_PC = 0, words 0x00000013, 0x00A00093 with out_ready = 1 -> two 32-bit instructions, out_pc 0x0 then 0x4, out_compressed = 0.
REQ-030 Word 0x45014581 -> 0x00004581 at pc 0, then 0x00004501 at pc 2, both out_compressed = 1.
REQ-031 Straddle: word 0x00134501 then word 0x45810000 -> 0x00004501 at pc 0, 0x00000013 at pc 2 (valid only after second accept), 0x00004581 at pc 6.
REQ-032 flush with flush_pc = 0x102, then word 0x4581xxxx -> halfword 0 dropped, 0x00004581 emitted at out_pc 0x102.
REQ-033 out_ready = 0 for 5 cycles with fetch_valid = 1 -> count saturates at 4, fetch_ready = 0, outputs stable; no parcel lost or duplicated after release.
